// File: rtl/sar_search_12_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM state encoding, default operand width and comparator flag positions.
package sar_search_12_pkg;

  localparam int DEF_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions in the {L,E,G} flag vector, matching the comparator's ordering.
  localparam int FLAG_L = 2;
  localparam int FLAG_E = 1;
  localparam int FLAG_G = 0;

endpackage

// File: rtl/sar_search_12.sv
// Successive-approximation search controller driving a combinational
// magnitude comparator's B operand and resolving one code bit per cycle.
module sar_search_12
  import sar_search_12_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_e,
  input  logic             cmp_g,
  input  logic             cmp_l,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_acc, w_acc_nx;
  logic [WIDTH-1:0] r_result, w_result_nx;
  logic [KW-1:0]    r_k, w_k_nx;
  logic             r_err, w_err_nx;

  logic [2:0]       w_flags;
  logic             w_onehot;
  logic             w_e;
  logic             w_g;
  logic [WIDTH-1:0] w_bit;
  logic [WIDTH-1:0] w_trial;

  assign w_flags[FLAG_L] = cmp_l;
  assign w_flags[FLAG_E] = cmp_e;
  assign w_flags[FLAG_G] = cmp_g;

  // A malformed flag set is flagged and otherwise behaves like L (bit cleared).
  assign w_onehot = (w_flags == 3'b001) || (w_flags == 3'b010) || (w_flags == 3'b100);
  assign w_e      = w_onehot & w_flags[FLAG_E];
  assign w_g      = w_onehot & w_flags[FLAG_G];

  assign w_bit   = {{(WIDTH-1){1'b0}}, 1'b1} << r_k;
  assign w_trial = (r_state == TEST) ? (r_acc | w_bit) : '0;

  assign trial  = w_trial;
  assign busy   = (r_state == TEST);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign err    = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_k      <= KW'(WIDTH-1);
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_acc    <= w_acc_nx;
      r_k      <= w_k_nx;
      r_result <= w_result_nx;
      r_err    <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_acc_nx    = r_acc;
    w_k_nx      = r_k;
    w_result_nx = r_result;
    w_err_nx    = r_err;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nx = TEST;
          w_acc_nx   = '0;
          w_k_nx     = KW'(WIDTH-1);
          w_err_nx   = 1'b0;
        end
      end
      TEST: begin
        if (!w_onehot) w_err_nx = 1'b1;
        if (EARLY_EXIT && w_e) begin
          w_result_nx = w_trial;
          w_state_nx  = DONE;
        end else begin
          if (w_g || w_e) w_acc_nx = w_trial;
          if (r_k == '0) begin
            w_result_nx = (w_g || w_e) ? w_trial : r_acc;
            w_state_nx  = DONE;
          end else begin
            w_k_nx = r_k - KW'(1);
          end
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

endmodule
